// File: rtl/reorder_buffer_pkg.sv
// Shared ROB constants and entry type encodings, also used by the register
// file and the decoder.
package reorder_buffer_pkg;

    localparam int ROB_SIZE    = 16;
    localparam int ROB_POS_WID = 4;                // log2(ROB_SIZE)
    localparam int ROB_ID_WID  = ROB_POS_WID + 1;  // rename tag is {1'b1, pos}
    localparam int DATA_WID    = 32;
    localparam int REG_POS_WID = 5;

    typedef enum logic [1:0] {
        ROB_T_REG   = 2'd0,
        ROB_T_STORE = 2'd1,
        ROB_T_BR    = 2'd2
    } rob_type_e;

    typedef logic [ROB_POS_WID-1:0] rob_pos_t;
    typedef logic [DATA_WID-1:0]    data_t;
    typedef logic [REG_POS_WID-1:0] reg_pos_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, operand lookup, writeback and retire signals of the reorder buffer.
// Names carry the direction as seen from the ROB (slave side).
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic     rdy_i;
    logic     issue_i;
    logic [1:0] issue_type_i;
    reg_pos_t issue_rd_i;
    logic     issue_ready_i;
    data_t    issue_val_i;
    logic     issue_pred_jump_i;
    rob_pos_t issue_pos_o;
    logic     rob_full_o;

    rob_pos_t q1_pos_i;
    rob_pos_t q2_pos_i;
    logic     q1_ready_o;
    logic     q2_ready_o;
    data_t    q1_val_o;
    data_t    q2_val_o;

    logic     alu_wb_i;
    rob_pos_t alu_wb_pos_i;
    data_t    alu_wb_val_i;
    logic     alu_wb_jump_i;
    data_t    alu_wb_pc_i;
    logic     lsb_wb_i;
    rob_pos_t lsb_wb_pos_i;
    data_t    lsb_wb_val_i;

    logic     commit_o;
    reg_pos_t commit_rd_o;
    data_t    commit_val_o;
    rob_pos_t commit_pos_o;
    logic     commit_store_o;
    logic     rollback_o;
    data_t    rollback_pc_o;

    modport slave (
        input  rdy_i, issue_i, issue_type_i, issue_rd_i, issue_ready_i, issue_val_i,
               issue_pred_jump_i, q1_pos_i, q2_pos_i,
               alu_wb_i, alu_wb_pos_i, alu_wb_val_i, alu_wb_jump_i, alu_wb_pc_i,
               lsb_wb_i, lsb_wb_pos_i, lsb_wb_val_i,
        output issue_pos_o, rob_full_o, q1_ready_o, q2_ready_o, q1_val_o, q2_val_o,
               commit_o, commit_rd_o, commit_val_o, commit_pos_o, commit_store_o,
               rollback_o, rollback_pc_o
    );

    modport master (
        output rdy_i, issue_i, issue_type_i, issue_rd_i, issue_ready_i, issue_val_i,
               issue_pred_jump_i, q1_pos_i, q2_pos_i,
               alu_wb_i, alu_wb_pos_i, alu_wb_val_i, alu_wb_jump_i, alu_wb_pc_i,
               lsb_wb_i, lsb_wb_pos_i, lsb_wb_val_i,
        input  issue_pos_o, rob_full_o, q1_ready_o, q2_ready_o, q1_val_o, q2_val_o,
               commit_o, commit_rd_o, commit_val_o, commit_pos_o, commit_store_o,
               rollback_o, rollback_pc_o
    );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order commit queue. Slots are allocated at the tail on issue,
// filled out of order by the ALU/LSB writeback ports, and retired one per
// cycle from the head. A mispredicted branch at the head flushes everything.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    reorder_buffer_if.slave rob_if
);

    // Per-entry state: flags are reset, payload is not
    logic [ROB_SIZE-1:0] busy_q, busy_d;
    logic [ROB_SIZE-1:0] ready_q, ready_d;
    logic [ROB_SIZE-1:0] pred_jump_q;
    logic [ROB_SIZE-1:0] real_jump_q;
    rob_type_e           type_q [ROB_SIZE];
    reg_pos_t            rd_q   [ROB_SIZE];
    data_t               val_q  [ROB_SIZE];
    data_t               pc_q   [ROB_SIZE];

    rob_pos_t              head_q, head_d;
    rob_pos_t              tail_q, tail_d;
    logic [ROB_ID_WID-1:0] count_q, count_d;

    logic     commit_q, commit_store_q, rollback_q;
    reg_pos_t commit_rd_q;
    data_t    commit_val_q, rollback_pc_q;
    rob_pos_t commit_pos_q;

    logic      full, accept, issue_ok, alu_ok, lsb_ok;
    logic      commit_fire, mispredict;
    rob_type_e head_type;

    // The cycle after a flush, new issues and writebacks belong to the
    // squashed path and are dropped.
    assign full        = (count_q == ROB_ID_WID'(ROB_SIZE));
    assign accept      = !rollback_q;
    assign issue_ok    = rob_if.issue_i && !full && accept;
    assign alu_ok      = rob_if.alu_wb_i && accept && busy_q[rob_if.alu_wb_pos_i];
    assign lsb_ok      = rob_if.lsb_wb_i && accept && busy_q[rob_if.lsb_wb_pos_i];
    assign head_type   = type_q[head_q];
    assign commit_fire = busy_q[head_q] && ready_q[head_q];
    assign mispredict  = commit_fire && (head_type == ROB_T_BR) &&
                         (real_jump_q[head_q] != pred_jump_q[head_q]);

    assign rob_if.issue_pos_o    = tail_q;
    assign rob_if.rob_full_o     = full;
    assign rob_if.commit_o       = commit_q;
    assign rob_if.commit_rd_o    = commit_rd_q;
    assign rob_if.commit_val_o   = commit_val_q;
    assign rob_if.commit_pos_o   = commit_pos_q;
    assign rob_if.commit_store_o = commit_store_q;
    assign rob_if.rollback_o     = rollback_q;
    assign rob_if.rollback_pc_o  = rollback_pc_q;

    // Operand lookup: a result on a writeback port forwards ahead of the stored value
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        rob_if.q1_ready_o = ready_q[rob_if.q1_pos_i];
        rob_if.q1_val_o   = val_q[rob_if.q1_pos_i];
        rob_if.q2_ready_o = ready_q[rob_if.q2_pos_i];
        rob_if.q2_val_o   = val_q[rob_if.q2_pos_i];
        if (rob_if.lsb_wb_i && rob_if.lsb_wb_pos_i == rob_if.q1_pos_i) begin
            rob_if.q1_ready_o = 1'b1;
            rob_if.q1_val_o   = rob_if.lsb_wb_val_i;
        end
        if (rob_if.alu_wb_i && rob_if.alu_wb_pos_i == rob_if.q1_pos_i) begin
            rob_if.q1_ready_o = 1'b1;
            rob_if.q1_val_o   = rob_if.alu_wb_val_i;
        end
        if (rob_if.lsb_wb_i && rob_if.lsb_wb_pos_i == rob_if.q2_pos_i) begin
            rob_if.q2_ready_o = 1'b1;
            rob_if.q2_val_o   = rob_if.lsb_wb_val_i;
        end
        if (rob_if.alu_wb_i && rob_if.alu_wb_pos_i == rob_if.q2_pos_i) begin
            rob_if.q2_ready_o = 1'b1;
            rob_if.q2_val_o   = rob_if.alu_wb_val_i;
        end
    end

    // Next state of the queue pointers and per-entry flags; a flush wins over all
    always_comb begin
        // NOTE: blocking assignments here let later rules override earlier ones in order.
        busy_d  = busy_q;
        ready_d = ready_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (alu_ok) ready_d[rob_if.alu_wb_pos_i] = 1'b1;
        if (lsb_ok) ready_d[rob_if.lsb_wb_pos_i] = 1'b1;
        if (commit_fire) begin
            busy_d[head_q]  = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (issue_ok) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = rob_if.issue_ready_i;
            tail_d          = tail_q + 1'b1;
        end
        unique case ({issue_ok, commit_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (mispredict) begin
            busy_d  = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Control state and registered retire outputs; rdy low freezes everything
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            busy_q         <= '0;
            ready_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_q       <= 1'b0;
            commit_store_q <= 1'b0;
            rollback_q     <= 1'b0;
            commit_rd_q    <= '0;
            commit_val_q   <= '0;
            commit_pos_q   <= '0;
            rollback_pc_q  <= '0;
        end else if (rob_if.rdy_i) begin
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_q       <= commit_fire && (head_type == ROB_T_REG) && (rd_q[head_q] != '0);
            commit_store_q <= commit_fire && (head_type == ROB_T_STORE);
            rollback_q     <= mispredict;
            if (commit_fire) begin
                commit_rd_q  <= rd_q[head_q];
                commit_val_q <= val_q[head_q];
                commit_pos_q <= head_q;
            end
            if (mispredict) rollback_pc_q <= pc_q[head_q];
        end
    end

    // Entry payload written at issue and writeback
    // NOTE: payload arrays carry no reset; busy/ready gate every read that matters.
    always_ff @(posedge clk) begin
        if (rob_if.rdy_i) begin
            if (issue_ok) begin
                type_q[tail_q]      <= rob_type_e'(rob_if.issue_type_i);
                rd_q[tail_q]        <= rob_if.issue_rd_i;
                pred_jump_q[tail_q] <= rob_if.issue_pred_jump_i;
                // A branch resolved at issue retires as correctly predicted
                real_jump_q[tail_q] <= rob_if.issue_pred_jump_i;
                if (rob_if.issue_ready_i) val_q[tail_q] <= rob_if.issue_val_i;
            end
            if (alu_ok) begin
                val_q[rob_if.alu_wb_pos_i]       <= rob_if.alu_wb_val_i;
                real_jump_q[rob_if.alu_wb_pos_i] <= rob_if.alu_wb_jump_i;
                pc_q[rob_if.alu_wb_pos_i]        <= rob_if.alu_wb_pc_i;
            end
            if (lsb_ok) val_q[rob_if.lsb_wb_pos_i] <= rob_if.lsb_wb_val_i;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios followed by a
// randomized run, all checked against an in-order queue model.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reorder_buffer_if rif ();
    reorder_buffer dut (.clk(clk), .rst(rst), .rob_if(rif));

    always #5 clk = ~clk;

    // Model: queue of live instructions, oldest first
    typedef struct {
        rob_type_e   t;
        logic [4:0]  rd;
        bit          rdy;
        logic [31:0] val;
        bit          pj;
        bit          rj;
        logic [31:0] pc;
        int          pos;
    } ent_t;

    ent_t        mq[$];
    int          m_tail;
    logic        e_commit, e_store, e_rb;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_rbpc;
    logic [3:0]  e_pos;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int find(input int pos);
        foreach (mq[i]) if (mq[i].pos == pos) return i;
        return -1;
    endfunction

    task automatic expect_q(input int pos, output logic r, output logic [31:0] v);
        int i;
        r = 1'b0;
        v = '0;
        if (rif.alu_wb_i && int'(rif.alu_wb_pos_i) == pos) begin
            r = 1'b1; v = rif.alu_wb_val_i;
        end else if (rif.lsb_wb_i && int'(rif.lsb_wb_pos_i) == pos) begin
            r = 1'b1; v = rif.lsb_wb_val_i;
        end else begin
            i = find(pos);
            if (i >= 0 && mq[i].rdy) begin r = 1'b1; v = mq[i].val; end
        end
    endtask

    task automatic check_comb();
        logic r;
        logic [31:0] v;
        if (mq.size() < ROB_SIZE) chk("issue_pos", rif.issue_pos_o, m_tail);
        chk("rob_full", rif.rob_full_o, mq.size() == ROB_SIZE);
        expect_q(rif.q1_pos_i, r, v);
        chk("q1_ready", rif.q1_ready_o, r);
        if (r) chk("q1_val", rif.q1_val_o, v);
        expect_q(rif.q2_pos_i, r, v);
        chk("q2_ready", rif.q2_ready_o, r);
        if (r) chk("q2_val", rif.q2_val_o, v);
    endtask

    task automatic check_regs();
        chk("commit", rif.commit_o, e_commit);
        chk("commit_store", rif.commit_store_o, e_store);
        chk("rollback", rif.rollback_o, e_rb);
        chk("commit_rd", rif.commit_rd_o, e_rd);
        chk("commit_val", rif.commit_val_o, e_val);
        chk("commit_pos", rif.commit_pos_o, e_pos);
        chk("rollback_pc", rif.rollback_pc_o, e_rbpc);
    endtask

    // One clock of the abstract machine: retire the oldest finished instruction,
    // apply results, append the new instruction; a wrong branch empties the queue.
    task automatic model_step();
        bit   full, accept, mis;
        int   ia, il;
        ent_t h, n;
        if (rst) begin
            mq.delete();
            m_tail = 0;
            e_commit = 0; e_store = 0; e_rb = 0;
            e_rd = '0; e_val = '0; e_pos = '0; e_rbpc = '0;
            return;
        end
        if (!rif.rdy_i) return;
        full   = (mq.size() == ROB_SIZE);
        accept = !e_rb;
        mis    = 0;
        e_commit = 0;
        e_store  = 0;
        if (mq.size() > 0 && mq[0].rdy) begin
            h = mq.pop_front();
            e_rd  = h.rd;
            e_val = h.val;
            e_pos = 4'(h.pos);
            case (h.t)
                ROB_T_REG:   e_commit = (h.rd != 0);
                ROB_T_STORE: e_store = 1;
                ROB_T_BR:    if (h.rj != h.pj) begin mis = 1; e_rbpc = h.pc; end
                default:     ;
            endcase
        end
        if (accept) begin
            if (rif.alu_wb_i) begin
                ia = find(rif.alu_wb_pos_i);
                if (ia >= 0) begin
                    mq[ia].rdy = 1;
                    mq[ia].val = rif.alu_wb_val_i;
                    mq[ia].rj  = rif.alu_wb_jump_i;
                    mq[ia].pc  = rif.alu_wb_pc_i;
                end
            end
            if (rif.lsb_wb_i) begin
                il = find(rif.lsb_wb_pos_i);
                if (il >= 0) begin
                    mq[il].rdy = 1;
                    mq[il].val = rif.lsb_wb_val_i;
                end
            end
            if (rif.issue_i && !full) begin
                n.t   = rob_type_e'(rif.issue_type_i);
                n.rd  = rif.issue_rd_i;
                n.rdy = rif.issue_ready_i;
                n.val = rif.issue_val_i;
                n.pj  = rif.issue_pred_jump_i;
                n.rj  = rif.issue_pred_jump_i;
                n.pc  = '0;
                n.pos = m_tail;
                mq.push_back(n);
                m_tail = (m_tail + 1) % ROB_SIZE;
            end
        end
        if (mis) begin
            mq.delete();
            m_tail = 0;
        end
        e_rb = mis;
    endtask

    task automatic idle();
        rif.rdy_i = 1'b1;
        rif.issue_i = 1'b0; rif.issue_type_i = '0; rif.issue_rd_i = '0;
        rif.issue_ready_i = 1'b0; rif.issue_val_i = '0; rif.issue_pred_jump_i = 1'b0;
        rif.q1_pos_i = '0; rif.q2_pos_i = '0;
        rif.alu_wb_i = 1'b0; rif.alu_wb_pos_i = '0; rif.alu_wb_val_i = '0;
        rif.alu_wb_jump_i = 1'b0; rif.alu_wb_pc_i = '0;
        rif.lsb_wb_i = 1'b0; rif.lsb_wb_pos_i = '0; rif.lsb_wb_val_i = '0;
    endtask

    task automatic tick();
        #1;
        if (!rst) check_comb();
        model_step();
        @(posedge clk);
        #1;
        check_regs();
        idle();
    endtask

    task automatic set_issue(input rob_type_e t, input int rd, input bit r,
                             input logic [31:0] v, input bit pj);
        rif.issue_i = 1'b1; rif.issue_type_i = t; rif.issue_rd_i = 5'(rd);
        rif.issue_ready_i = r; rif.issue_val_i = v; rif.issue_pred_jump_i = pj;
    endtask

    task automatic set_alu(input int pos, input logic [31:0] v, input bit j, input logic [31:0] pc);
        rif.alu_wb_i = 1'b1; rif.alu_wb_pos_i = 4'(pos); rif.alu_wb_val_i = v;
        rif.alu_wb_jump_i = j; rif.alu_wb_pc_i = pc;
    endtask

    task automatic set_lsb(input int pos, input logic [31:0] v);
        rif.lsb_wb_i = 1'b1; rif.lsb_wb_pos_i = 4'(pos); rif.lsb_wb_val_i = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int  pend[$];
    int  a, l, k;
    bit  jmp, rr;
    rob_type_e tt;

    initial begin
        idle();

        // Reset state
        do_reset();
        chk("rst_full", rif.rob_full_o, 1'b0);
        chk("rst_issue_pos", rif.issue_pos_o, 4'd0);
        chk("rst_commit", rif.commit_o, 1'b0);
        chk("rst_rollback", rif.rollback_o, 1'b0);

        // Issue already-ready reg write, retires on the next edge
        set_issue(ROB_T_REG, 5, 1, 32'h1234, 0);
        tick();
        tick();
        chk("t1_commit", rif.commit_o, 1'b1);
        chk("t1_rd", rif.commit_rd_o, 5'd5);
        chk("t1_val", rif.commit_val_o, 32'h1234);
        chk("t1_pos", rif.commit_pos_o, 4'd0);
        tick();
        chk("t1_one_cycle", rif.commit_o, 1'b0);

        // Out-of-order writeback, in-order retire
        do_reset();
        set_issue(ROB_T_REG, 1, 0, 0, 0); tick();
        set_issue(ROB_T_REG, 2, 0, 0, 0); tick();
        set_alu(1, 32'd7, 0, 0); tick();
        set_lsb(0, 32'd3); tick();
        tick();
        chk("t2_first_pos", rif.commit_pos_o, 4'd0);
        chk("t2_first_val", rif.commit_val_o, 32'd3);
        tick();
        chk("t2_second_pos", rif.commit_pos_o, 4'd1);
        chk("t2_second_val", rif.commit_val_o, 32'd7);

        // Fill, overflow attempt, retire one, wrap the tail
        do_reset();
        for (int i = 0; i < ROB_SIZE; i++) begin
            set_issue(ROB_T_REG, i + 1, 0, 0, 0);
            tick();
        end
        chk("t3_full", rif.rob_full_o, 1'b1);
        set_issue(ROB_T_REG, 9, 1, 32'hdead, 0);
        tick();
        chk("t3_full_ignore", rif.rob_full_o, 1'b1);
        set_alu(0, 32'h55, 0, 0); tick();
        tick();
        chk("t3_commit_val", rif.commit_val_o, 32'h55);
        chk("t3_not_full", rif.rob_full_o, 1'b0);
        chk("t3_wrap_pos", rif.issue_pos_o, 4'd0);
        set_issue(ROB_T_REG, 20, 0, 0, 0); tick();
        chk("t3_tail_after_wrap", rif.issue_pos_o, 4'd1);
        chk("t3_full_again", rif.rob_full_o, 1'b1);

        // Branch mispredict and the dead cycle after it
        do_reset();
        set_issue(ROB_T_REG, 3, 1, 32'h33, 0); tick();
        set_issue(ROB_T_REG, 4, 1, 32'h44, 0); tick();
        set_issue(ROB_T_BR, 0, 0, 0, 0); tick();
        set_issue(ROB_T_REG, 6, 0, 0, 0); tick();
        set_alu(2, 32'h0, 1, 32'h100); tick();
        tick();
        chk("t4_rollback", rif.rollback_o, 1'b1);
        chk("t4_rollback_pc", rif.rollback_pc_o, 32'h100);
        chk("t4_not_full", rif.rob_full_o, 1'b0);
        chk("t4_issue_pos", rif.issue_pos_o, 4'd0);
        set_issue(ROB_T_REG, 7, 1, 32'h77, 0);
        set_lsb(3, 32'h99);
        tick();
        chk("t4_rollback_done", rif.rollback_o, 1'b0);
        chk("t4_issue_dropped", rif.issue_pos_o, 4'd0);
        rif.q1_pos_i = 4'd3;
        #1;
        chk("t4_young_not_ready", rif.q1_ready_o, 1'b0);
        tick();
        chk("t4_no_commit", rif.commit_o, 1'b0);

        // Same-cycle forwarding from the ALU port, then the stored value
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_issue(ROB_T_REG, i + 10, 0, 0, 0);
            tick();
        end
        set_alu(3, 32'd9, 0, 0);
        rif.q1_pos_i = 4'd3;
        #1;
        chk("t5_fwd_ready", rif.q1_ready_o, 1'b1);
        chk("t5_fwd_val", rif.q1_val_o, 32'd9);
        tick();
        rif.q2_pos_i = 4'd3;
        rif.q1_pos_i = 4'd2;
        #1;
        chk("t5_stored_ready", rif.q2_ready_o, 1'b1);
        chk("t5_stored_val", rif.q2_val_o, 32'd9);
        chk("t5_other_pending", rif.q1_ready_o, 1'b0);
        tick();

        // Store retire and a write to r0
        do_reset();
        set_issue(ROB_T_STORE, 0, 1, 0, 0); tick();
        tick();
        chk("t6_store", rif.commit_store_o, 1'b1);
        chk("t6_store_no_commit", rif.commit_o, 1'b0);
        set_issue(ROB_T_REG, 0, 1, 32'habc, 0); tick();
        chk("t6_store_one_cycle", rif.commit_store_o, 1'b0);
        tick();
        chk("t6_rd0_no_commit", rif.commit_o, 1'b0);
        chk("t6_rd0_pos", rif.commit_pos_o, 4'd1);

        // Randomized traffic against the model, with rdy stalls
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rif.rdy_i = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 5);
                if (k < 2) tt = ROB_T_BR;
                else if (k == 2) tt = ROB_T_STORE;
                else tt = ROB_T_REG;
                rr = (tt != ROB_T_BR) && ($urandom_range(0, 2) == 0);
                set_issue(tt, $urandom_range(0, 31), rr, $urandom, 1'($urandom_range(0, 1)));
            end
            pend.delete();
            foreach (mq[i]) if (!mq[i].rdy) pend.push_back(i);
            if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                a = pend[$urandom_range(0, pend.size() - 1)];
                if (mq[a].t == ROB_T_BR) jmp = ($urandom_range(0, 7) == 0) ? !mq[a].pj : mq[a].pj;
                else jmp = 1'($urandom_range(0, 1));
                set_alu(mq[a].pos, $urandom, jmp, $urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                set_alu($urandom_range(0, 15), $urandom, 1'($urandom_range(0, 1)), $urandom);
            end
            if (pend.size() > 1 && $urandom_range(0, 2) == 0) begin
                l = pend[$urandom_range(0, pend.size() - 1)];
                if (!(rif.alu_wb_i && int'(rif.alu_wb_pos_i) == mq[l].pos))
                    set_lsb(mq[l].pos, $urandom);
            end
            rif.q1_pos_i = 4'($urandom_range(0, 15));
            rif.q2_pos_i = 4'($urandom_range(0, 15));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
